// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: strips prefix/break bytes, tracks shift/caps-lock and
// queues key-presses as {scan_code, letter_case, extended} in a show-ahead FIFO.
module ps2_key_tracker #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       key_rd,
  output logic [7:0] scan_code,
  output logic       letter_case,
  output logic       key_extended,
  output logic       key_empty,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned EW    = 10;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t             state, state_nx;
  logic [2:0]         skip_cnt, skip_nx;
  logic               lshift, rshift, caps_held;
  logic               make_v, brk_v, ext_v;
  logic               is_mod, is_letter, case_bit, push_c, pop_c, full_c, wr_en_c;
  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
    end
  end

  // Byte sequencer: classifies each received byte as make, break or filler.
  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    make_v   = 1'b0;
    brk_v    = 1'b0;
    ext_v    = 1'b0;
    if (rx_done_tick) begin
      case (state)
        IDLE: begin
          case (rx_data)
            8'hE0: state_nx = EXT;
            8'hF0: state_nx = BRK;
            8'hE1: begin
              state_nx = SKIP;
              skip_nx  = 3'd7;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nx = IDLE;
            default: make_v = 1'b1;
          endcase
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_nx = EXT_BRK;
          end else if (rx_data != 8'hE0) begin
            make_v   = 1'b1;
            ext_v    = 1'b1;
            state_nx = IDLE;
          end
        end
        BRK: begin
          brk_v    = 1'b1;
          state_nx = IDLE;
        end
        EXT_BRK: begin
          brk_v    = 1'b1;
          ext_v    = 1'b1;
          state_nx = IDLE;
        end
        SKIP: begin
          skip_nx = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Key classification and FIFO handshake.
  always_comb begin
    is_mod    = rx_data inside {8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
    is_letter = !ext_v && (rx_data inside {8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
      8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
      8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A});
    case_bit  = (lshift | rshift) ^ (caps_lock & is_letter);
    push_c    = make_v && !is_mod && !(ext_v && rx_data == 8'h7C);
    pop_c     = key_rd && (count != CW'(0));
    full_c    = (count == CW'(DEPTH));
    wr_en_c   = push_c && (!full_c || pop_c);
  end

  // Modifier tracking; caps only toggles on the first make of a hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (make_v) begin
      if (!ext_v && rx_data == 8'h12) lshift <= 1'b1;
      if (!ext_v && rx_data == 8'h59) rshift <= 1'b1;
      if (rx_data == 8'h58) begin
        caps_held <= 1'b1;
        if (!caps_held) caps_lock <= ~caps_lock;
      end
    end else if (brk_v) begin
      if (rx_data == 8'h12) lshift    <= 1'b0;
      if (rx_data == 8'h59) rshift    <= 1'b0;
      if (rx_data == 8'h58) caps_held <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= {rx_data, case_bit, ext_v};
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_c && !wr_en_c) overflow <= 1'b1;
      if (wr_en_c && !pop_c) count <= count + CW'(1);
      else if (!wr_en_c && pop_c) count <= count - CW'(1);
    end
  end

  // Show-ahead head entry straight from storage.
  assign scan_code    = mem[rd_ptr][9:2];
  assign letter_case  = mem[rd_ptr][1];
  assign key_extended = mem[rd_ptr][0];
  assign key_empty    = (count == CW'(0));

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed table-driven bench for ps2_key_tracker plus reset and
// full-FIFO simultaneous push/pop sequences.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       key_rd;
  logic [7:0] scan_code;
  logic       letter_case;
  logic       key_extended;
  logic       key_empty;
  logic       caps_lock;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ps2_key_tracker #(.FIFO_AW(2)) dut (
    .clk(clk), .resetn(resetn), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .key_rd(key_rd), .scan_code(scan_code), .letter_case(letter_case),
    .key_extended(key_extended), .key_empty(key_empty), .caps_lock(caps_lock),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       rd;
    logic       e;
    logic [7:0] code;
    logic       cs;
    logic       ex;
    logic       cp;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic tick, logic [7:0] data, logic rd, logic e,
                              logic [7:0] code, logic cs, logic ex, logic cp, logic ov);
    vec_t v;
    v.tick = tick; v.data = data; v.rd = rd; v.e = e; v.code = code;
    v.cs = cs; v.ex = ex; v.cp = cp; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input int idx, input logic e, input logic [7:0] code, input logic cs,
                           input logic ex, input logic cp, input logic ov);
    chk("key_empty", idx, 8'(key_empty), 8'(e));
    chk("caps_lock", idx, 8'(caps_lock), 8'(cp));
    chk("overflow", idx, 8'(overflow), 8'(ov));
    if (!e) begin
      chk("scan_code", idx, scan_code, code);
      chk("letter_case", idx, 8'(letter_case), 8'(cs));
      chk("key_extended", idx, 8'(key_extended), 8'(ex));
    end
  endtask

  task automatic cycle(input logic tick, input logic [7:0] data, input logic rd);
    rx_done_tick = tick;
    rx_data      = data;
    key_rd       = rd;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    key_rd       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    rx_done_tick = 1'b0;
    key_rd = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic add_same(input logic [7:0] data, input logic [7:0] code, input logic cs,
                          input logic ex, input logic cp, input logic ov);
    vecs.push_back(mk(1, data, 0, 0, code, cs, ex, cp, ov));
  endtask

  initial begin
    byte unsigned seq4 [15];
    resetn = 1'b1;
    rx_done_tick = 1'b0;
    rx_data = 8'h00;
    key_rd = 1'b0;

    // Make/break of a single letter.
    vecs.push_back(mk(1, 8'h1C, 0, 0, 8'h1C, 0, 0, 0, 0));
    add_same(8'hF0, 8'h1C, 0, 0, 0, 0);
    add_same(8'h1C, 8'h1C, 0, 0, 0, 0);
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0));
    // Shifted digit, then unshifted after shift release.
    vecs.push_back(mk(1, 8'h12, 0, 1, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h16, 0, 0, 8'h16, 1, 0, 0, 0));
    add_same(8'hF0, 8'h16, 1, 0, 0, 0);
    add_same(8'h16, 8'h16, 1, 0, 0, 0);
    add_same(8'hF0, 8'h16, 1, 0, 0, 0);
    add_same(8'h12, 8'h16, 1, 0, 0, 0);
    add_same(8'h16, 8'h16, 1, 0, 0, 0);
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h16, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0));
    // Caps-lock with typematic repeat, letter vs digit.
    vecs.push_back(mk(1, 8'h58, 0, 1, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h58, 0, 1, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'hF0, 0, 1, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h58, 0, 1, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h1C, 0, 0, 8'h1C, 1, 0, 1, 0));
    add_same(8'h16, 8'h1C, 1, 0, 1, 0);
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h16, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h58, 0, 1, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'hF0, 0, 1, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h58, 0, 1, 8'h00, 0, 0, 0, 0));
    // Extended key, filtered print-screen/pause/responses.
    vecs.push_back(mk(1, 8'hE0, 0, 1, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h75, 0, 0, 8'h75, 0, 1, 0, 0));
    seq4 = '{8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'hE1, 8'h14, 8'h77,
             8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'hFA};
    foreach (seq4[i]) add_same(seq4[i], 8'h75, 0, 1, 0, 0);
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h1C, 0, 0, 8'h1C, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0));
    // Simultaneous push/pop at count 1: new entry becomes head.
    vecs.push_back(mk(1, 8'h16, 0, 0, 8'h16, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h1C, 1, 0, 8'h1C, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0));
    // Overflow, drain in order, wrap.
    vecs.push_back(mk(1, 8'h15, 0, 0, 8'h15, 0, 0, 0, 0));
    add_same(8'h1D, 8'h15, 0, 0, 0, 0);
    add_same(8'h24, 8'h15, 0, 0, 0, 0);
    add_same(8'h2D, 8'h15, 0, 0, 0, 0);
    add_same(8'h2C, 8'h15, 0, 0, 0, 1);
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h1D, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h24, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h2D, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h35, 0, 0, 8'h35, 0, 0, 0, 1));
    add_same(8'h1A, 8'h35, 0, 0, 0, 1);
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h1A, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 1));
    // Reads while empty must not move pointers.
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h1D, 0, 0, 8'h1D, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 1));

    do_reset();
    chk("reset_empty", 0, 8'(key_empty), 8'h01);
    chk("reset_scan_code", 0, scan_code, 8'h00);
    chk("reset_letter_case", 0, 8'(letter_case), 8'h00);
    chk("reset_extended", 0, 8'(key_extended), 8'h00);
    chk("reset_caps", 0, 8'(caps_lock), 8'h00);
    chk("reset_overflow", 0, 8'(overflow), 8'h00);

    foreach (vecs[i]) begin
      cycle(vecs[i].tick, vecs[i].data, vecs[i].rd);
      check_out(i + 1, vecs[i].e, vecs[i].code, vecs[i].cs, vecs[i].ex, vecs[i].cp, vecs[i].ov);
    end

    // Reset between E0 and 75 with caps on and overflow set.
    cycle(1, 8'h58, 0);
    check_out(1000, 1, 8'h00, 0, 0, 1, 1);
    cycle(1, 8'hE0, 0);
    do_reset();
    check_out(1001, 1, 8'h00, 0, 0, 0, 0);
    chk("reset_scan_code_2", 1001, scan_code, 8'h00);
    cycle(1, 8'h75, 0);
    check_out(1002, 0, 8'h75, 0, 0, 0, 0);

    // Full FIFO with simultaneous push and pop: nothing dropped.
    do_reset();
    cycle(1, 8'h15, 0);
    cycle(1, 8'h1D, 0);
    cycle(1, 8'h24, 0);
    cycle(1, 8'h2D, 0);
    check_out(2000, 0, 8'h15, 0, 0, 0, 0);
    cycle(1, 8'h4D, 1);
    check_out(2001, 0, 8'h1D, 0, 0, 0, 0);
    cycle(0, 8'h00, 1);
    check_out(2002, 0, 8'h24, 0, 0, 0, 0);
    cycle(0, 8'h00, 1);
    check_out(2003, 0, 8'h2D, 0, 0, 0, 0);
    cycle(0, 8'h00, 1);
    check_out(2004, 0, 8'h4D, 0, 0, 0, 0);
    cycle(0, 8'h00, 1);
    check_out(2005, 1, 8'h00, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
